// File: rtl/axi_llc_lock_requester_if.sv
// rtl/axi_llc_lock_requester_if.sv - LLC config/descriptor types and the lock requester bus interface
// slave = requester view; master = upstream/lock-box/downstream environment view.
package axi_llc_pkg;
  typedef struct packed {
    int unsigned IndexLength;
    int unsigned SetAssociativity;
  } llc_cfg_t;

  localparam llc_cfg_t DefaultCfg = '{IndexLength: 32'd8, SetAssociativity: 32'd4};

  typedef struct packed {
    logic [7:0] tag;
    logic [7:0] index;
    logic [3:0] way_ind;
  } llc_desc_t;

  typedef struct packed {
    logic [7:0] index;
    logic [3:0] way_ind;
  } llc_lock_t;
endpackage

interface axi_llc_lock_requester_if #(
  parameter type desc_t = axi_llc_pkg::llc_desc_t,
  parameter type lock_t = axi_llc_pkg::llc_lock_t
);
  desc_t desc;
  logic  desc_valid;
  logic  desc_ready;
  lock_t lock;
  logic  lock_req;
  logic  locked;
  desc_t fwd_desc;
  logic  fwd_valid;
  logic  fwd_ready;

  modport slave (
    input  desc, desc_valid, locked, fwd_ready,
    output desc_ready, lock, lock_req, fwd_desc, fwd_valid
  );

  modport master (
    output desc, desc_valid, locked, fwd_ready,
    input  desc_ready, lock, lock_req, fwd_desc, fwd_valid
  );
endinterface

// File: rtl/axi_llc_lock_requester.sv
// rtl/axi_llc_lock_requester.sv - LLC line-lock initiator: lookup, wait while locked, lock, forward
// Optional saturating stall counter on stall_cnt_o when AXI_LLC_LOCK_STALL_CNT_EN is defined.
module axi_llc_lock_requester #(
  parameter axi_llc_pkg::llc_cfg_t Cfg = axi_llc_pkg::DefaultCfg,
  parameter type desc_t = axi_llc_pkg::llc_desc_t,
  parameter type lock_t = axi_llc_pkg::llc_lock_t
`ifdef AXI_LLC_LOCK_STALL_CNT_EN
  ,
  parameter int unsigned StallCntWidth = 16
`endif
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  axi_llc_lock_requester_if.slave        bus_io,
  output logic                           busy_o
`ifdef AXI_LLC_LOCK_STALL_CNT_EN
  ,
  output logic [StallCntWidth-1:0]       stall_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, LOOKUP, SEND} state_e;

  state_e state_q;
  desc_t  desc_q;
  logic   valid_q;
  logic   busy_q;

  logic [Cfg.IndexLength-1:0]      lock_index;
  logic [Cfg.SetAssociativity-1:0] lock_way;

  assign lock_index = desc_q.index;
  assign lock_way   = desc_q.way_ind;

  // The lock strobe must react to locked in the same cycle, so it is a state decode.
  assign bus_io.lock       = lock_t'{index: lock_index, way_ind: lock_way};
  assign bus_io.lock_req   = (state_q == LOOKUP) && !bus_io.locked;
  assign bus_io.desc_ready = (state_q == IDLE) || (valid_q && bus_io.fwd_ready);
  assign bus_io.fwd_desc   = desc_q;
  assign bus_io.fwd_valid  = valid_q;
  assign busy_o            = busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      desc_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_io.desc_valid) begin
            desc_q  <= bus_io.desc;
            state_q <= LOOKUP;
            busy_q  <= 1'b1;
          end
        end
        LOOKUP: begin
          if (!bus_io.locked) begin
            state_q <= SEND;
            valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (bus_io.fwd_ready) begin
            valid_q <= 1'b0;
            // A waiting descriptor is taken in the same cycle to reach one per two cycles.
            if (bus_io.desc_valid) begin
              desc_q  <= bus_io.desc;
              state_q <= LOOKUP;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXI_LLC_LOCK_STALL_CNT_EN
  logic [StallCntWidth-1:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if ((state_q == LOOKUP) && bus_io.locked && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axi_llc_lock_requester.sv
// tb/tb_axi_llc_lock_requester.sv - directed bench for axi_llc_lock_requester
// Define AXI_LLC_LOCK_STALL_CNT_EN to also exercise the 4-bit saturating stall counter.
module tb_axi_llc_lock_requester;
  import axi_llc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;

  logic use_model = 1'b0;
  logic locked_drv = 1'b0;
  logic rel = 1'b0;
  logic held_q = 1'b0;
  llc_lock_t line_q = '0;
  int   req_cnt = 0;
  int   req_base;

  axi_llc_lock_requester_if bus ();

`ifdef AXI_LLC_LOCK_STALL_CNT_EN
  logic [3:0] stall_cnt;
`endif

  axi_llc_lock_requester #(
`ifdef AXI_LLC_LOCK_STALL_CNT_EN
    .StallCntWidth(4)
`endif
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus.slave),
    .busy_o(busy)
`ifdef AXI_LLC_LOCK_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural lock box: registered increment on lock_req, explicit release.
  always @(posedge clk) begin
    if (rel) held_q <= 1'b0;
    else if (bus.lock_req) begin
      held_q <= 1'b1;
      line_q <= bus.lock;
    end
    if (bus.lock_req) req_cnt <= req_cnt + 1;
  end

  assign bus.locked = use_model ? (held_q && (bus.lock == line_q)) : locked_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  llc_desc_t da, db, dx;

  initial begin
    bus.desc = '0;
    bus.desc_valid = 1'b0;
    bus.fwd_ready = 1'b0;

    // Reset state
    smp();
    chk("rst_ready", 32'(bus.desc_ready), 32'd1);
    chk("rst_lock_req", 32'(bus.lock_req), 32'd0);
    chk("rst_valid", 32'(bus.fwd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lock", 32'(bus.lock), 32'd0);
    adv();
    rst_n = 1'b1;

    // 1: accept, lock at +1, forward at +2
    da = '{tag: 8'hA5, index: 8'd5, way_ind: 4'b0001};
    bus.desc = da;
    bus.desc_valid = 1'b1;
    smp();
    chk("t1_ready_c0", 32'(bus.desc_ready), 32'd1);
    chk("t1_no_req_c0", 32'(bus.lock_req), 32'd0);
    adv();
    dx = '{tag: 8'h3C, index: 8'd9, way_ind: 4'b1000};
    bus.desc = dx;
    smp();
    chk("t1_req_c1", 32'(bus.lock_req), 32'd1);
    chk("t1_lock_c1", 32'(bus.lock), 32'h051);
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_novalid_c1", 32'(bus.fwd_valid), 32'd0);
    adv();
    smp();
    chk("t1_valid_c2", 32'(bus.fwd_valid), 32'd1);
    chk("t1_desc_c2", 32'(bus.fwd_desc), 32'(da));
    chk("t1_no_req_c2", 32'(bus.lock_req), 32'd0);

    // 3: downstream stall for 5 cycles, new descriptor pending but not taken
    for (int i = 0; i < 5; i++) begin
      if (i > 0) smp();
      chk("t3_desc_stable", 32'(bus.fwd_desc), 32'(da));
      chk("t3_ready_low", 32'(bus.desc_ready), 32'd0);
      chk("t3_no_req", 32'(bus.lock_req), 32'd0);
      adv();
    end
    bus.desc_valid = 1'b0;
    bus.fwd_ready = 1'b1;
    smp();
    chk("t3_ready_follows", 32'(bus.desc_ready), 32'd1);
    adv();
    bus.fwd_ready = 1'b0;
    smp();
    chk("t3_idle_valid", 32'(bus.fwd_valid), 32'd0);
    chk("t3_idle_busy", 32'(busy), 32'd0);
    chk("t3_idle_ready", 32'(bus.desc_ready), 32'd1);

    // 2: locked for 10 cycles
    db = '{tag: 8'h02, index: 8'd9, way_ind: 4'b0100};
    bus.desc = db;
    bus.desc_valid = 1'b1;
    locked_drv = 1'b1;
    adv();
    bus.desc_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("t2_req_held", 32'(bus.lock_req), 32'd0);
      adv();
    end
    locked_drv = 1'b0;
    smp();
    chk("t2_req_released", 32'(bus.lock_req), 32'd1);
    chk("t2_lock", 32'(bus.lock), 32'h094);
`ifdef AXI_LLC_LOCK_STALL_CNT_EN
    chk("t2_stall_cnt", 32'(stall_cnt), 32'd10);
`endif
    adv();
    smp();
    chk("t2_valid", 32'(bus.fwd_valid), 32'd1);
    chk("t2_desc", 32'(bus.fwd_desc), 32'(db));
    bus.fwd_ready = 1'b1;
    adv();

    // 4: back-to-back same line with the lock box model
    use_model = 1'b1;
    req_base = req_cnt;
    da = '{tag: 8'h11, index: 8'd7, way_ind: 4'b0010};
    db = '{tag: 8'h22, index: 8'd7, way_ind: 4'b0010};
    bus.desc = da;
    bus.desc_valid = 1'b1;
    adv();
    bus.desc = db;
    smp();
    chk("t4_req_a", 32'(bus.lock_req), 32'd1);
    adv();
    smp();
    chk("t4_send_a", 32'(bus.fwd_desc), 32'(da));
    chk("t4_take_b", 32'(bus.desc_ready), 32'd1);
    adv();
    bus.desc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t4_b_waits", 32'(bus.lock_req), 32'd0);
      adv();
    end
    rel = 1'b1;
    adv();
    rel = 1'b0;
    smp();
    chk("t4_req_b", 32'(bus.lock_req), 32'd1);
    adv();
    smp();
    chk("t4_send_b", 32'(bus.fwd_desc), 32'(db));
    chk("t4_req_total", 32'(req_cnt - req_base), 32'd2);
    adv();
    smp();
    chk("t4_idle", 32'(busy), 32'd0);
    use_model = 1'b0;
    bus.fwd_ready = 1'b0;

    // 5: async reset while stalled in lookup
    locked_drv = 1'b1;
    bus.desc = da;
    bus.desc_valid = 1'b1;
    adv();
    bus.desc_valid = 1'b0;
    adv();
    smp();
    chk("t5_busy_before", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_busy", 32'(busy), 32'd0);
    smp();
    chk("t5_req", 32'(bus.lock_req), 32'd0);
    chk("t5_valid", 32'(bus.fwd_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready", 32'(bus.desc_ready), 32'd1);
`ifdef AXI_LLC_LOCK_STALL_CNT_EN
    chk("t5_stall_clr", 32'(stall_cnt), 32'd0);
`endif
    adv();
    rst_n = 1'b1;
    smp();
    chk("t5_ready_after", 32'(bus.desc_ready), 32'd1);

`ifdef AXI_LLC_LOCK_STALL_CNT_EN
    // 6: 20 stall cycles saturate a 4-bit counter
    bus.desc = db;
    bus.desc_valid = 1'b1;
    adv();
    bus.desc_valid = 1'b0;
    for (int i = 0; i < 20; i++) adv();
    smp();
    chk("t6_stall_sat", 32'(stall_cnt), 32'd15);
    locked_drv = 1'b0;
    adv();
    smp();
    chk("t6_stall_hold", 32'(stall_cnt), 32'd15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
